dff_pipe: RTL and testbench

Parametrised, elastic successor to the 16-bit `dff`. It is a chain of DEPTH valid/ready register stages, each WIDTH bits wide. Stages collapse bubbles, stall under back-pressure without losing data and report occupancy. It sits between datapath blocks wherever a timing cut or a small elastic buffer is needed, such as the ALU-to-writeback path or the memory response path.

---
 rtl/dff_pkg.sv | 22 ++
 rtl/dff_pipe_if.sv | 58 +++++
 rtl/dff_en.sv | 39 +++
 rtl/dff_pipe.sv | 136 +++++++++++++
 tb/tb_dff_pipe.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dff_pkg.sv
// -----------------------------------------------------------------------------
// dff_pkg
// Shared definitions for the dff_pipe elastic register chain.
//   - Default payload width and stage count.
//   - count_width(): width of the occupancy counter, $clog2(DEPTH+1) clamped to
//     at least one bit so a DEPTH that would yield zero still gets a real port.
// Optional feature macro used by this slice: DFF_PIPE_FLUSH_EN (adds a flush
// port that empties the pipe).
// -----------------------------------------------------------------------------
package dff_pkg;

    localparam int DFF_WIDTH_DEF = 32;
    localparam int DFF_DEPTH_DEF = 2;

    // Occupancy counter width: enough bits to represent 0..depth.
    function automatic int count_width(input int depth);
        int w;
        w = $clog2(depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : dff_pkg

// File: rtl/dff_pipe_if.sv
// -----------------------------------------------------------------------------
// dff_pipe_if
// Upstream/downstream valid-ready bundle for dff_pipe.
//   in_valid/in_data/in_ready    : upstream handshake (producer -> pipe)
//   out_valid/out_data/out_ready : downstream handshake (pipe -> consumer)
//   count                        : number of occupied stages
//   flush                        : only when DFF_PIPE_FLUSH_EN is defined
// Modports:
//   master : the environment around the pipe (drives in_*, out_ready, flush)
//   slave  : the pipe itself
// -----------------------------------------------------------------------------
interface dff_pipe_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH_DEF,
    parameter int DEPTH = DFF_DEPTH_DEF
);

    localparam int CW = count_width(DEPTH);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;
`ifdef DFF_PIPE_FLUSH_EN
    logic             flush;
`endif

    modport master (
`ifdef DFF_PIPE_FLUSH_EN
        output flush,
`endif
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  count
    );

    modport slave (
`ifdef DFF_PIPE_FLUSH_EN
        input  flush,
`endif
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output count
    );

endinterface : dff_pipe_if

// File: rtl/dff_en.sv
// -----------------------------------------------------------------------------
// dff_en
// Single WIDTH-bit data register with synchronous active-low reset and a load
// enable. Holds its value whenever i_en is low.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low; clears the register to zero
//   i_en  : load enable
//   i_d   : next value
//   o_q   : registered value
// -----------------------------------------------------------------------------
module dff_en
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Data register: reset clears, enable loads, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule : dff_en

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
// Elastic chain of DEPTH valid/ready register stages, WIDTH bits each. Bubbles
// collapse toward the output, back-pressure stalls without loss, and the
// number of occupied stages is reported as registered state.
// Parameters:
//   WIDTH : payload bits per stage (>= 1)
//   DEPTH : number of stages (>= 1); out_ready->in_ready is combinational
//           through every stage, so keep DEPTH small (<= 4)
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low; clears all valid bits and data
//   bus   : dff_pipe_if.slave (in_*, out_*, count, and flush when
//           DFF_PIPE_FLUSH_EN is defined)
// Optional feature macro: DFF_PIPE_FLUSH_EN -- flush clears all valid bits
// (data untouched) and discards any beat offered in the same cycle.
// -----------------------------------------------------------------------------
module dff_pipe
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH_DEF,
    parameter int DEPTH = DFF_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      reset,
    dff_pipe_if.slave bus
);

    localparam int CW = count_width(DEPTH);

    // Registered state: one valid bit per stage plus the occupancy count.
    logic [DEPTH-1:0] r_v;
    logic [CW-1:0]    r_count;

    // Per-stage combinational control.
    logic [DEPTH-1:0] w_adv;     // stage hands its content onward this cycle
    logic [DEPTH-1:0] w_rdy;     // stage can take a new value this cycle
    logic [DEPTH-1:0] w_v_in;    // valid presented to each stage from behind
    logic [DEPTH-1:0] w_v_next;
    logic [DEPTH-1:0] w_ld;      // data register load enables
    logic [CW-1:0]    w_count_next;
    logic             w_flush;

    logic [WIDTH-1:0] w_q    [DEPTH];
    logic [WIDTH-1:0] w_d_in [DEPTH];

`ifdef DFF_PIPE_FLUSH_EN
    assign w_flush = bus.flush;
`else
    assign w_flush = 1'b0;
`endif

    // Handshake chain, next valid bits, data load enables and next count.
    always_comb begin
        w_adv        = '0;
        w_rdy        = '0;
        w_v_in       = '0;
        w_v_next     = r_v;
        w_ld         = '0;
        w_count_next = '0;

        // Advance propagates backward from the output: a stage may move on
        // if its successor is empty or is itself moving on.
        w_adv[DEPTH-1] = bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = !r_v[i+1] || w_adv[i+1];
        end

        w_v_in[0] = bus.in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            w_v_in[i] = r_v[i-1];
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i] = !r_v[i] || w_adv[i];
            if (w_rdy[i]) begin
                w_v_next[i] = w_v_in[i];
            end else begin
                w_v_next[i] = r_v[i];
            end
            // Data only moves when a real beat arrives, so empty stages keep
            // their last payload; flush leaves data untouched.
            w_ld[i] = w_rdy[i] && w_v_in[i] && !w_flush;
        end

        if (w_flush) begin
            w_v_next = '0;
        end else begin
            w_v_next = w_v_next;
        end

        for (int i = 0; i < DEPTH; i++) begin
            w_count_next = w_count_next + CW'(w_v_next[i]);
        end
    end

    // Data input of each stage: upstream payload for stage 0, else predecessor.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_d_in[i] = '0;
        end
        w_d_in[0] = bus.in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_d_in[i] = w_q[i-1];
        end
    end

    // Valid bits and occupancy count; reset wins over flush and traffic.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_v     <= '0;
            r_count <= '0;
        end else begin
            r_v     <= w_v_next;
            r_count <= w_count_next;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff_en #(
            .WIDTH (WIDTH)
        ) u_data (
            .clk   (clk),
            .reset (reset),
            .i_en  (w_ld[g]),
            .i_d   (w_d_in[g]),
            .o_q   (w_q[g])
        );
    end

    assign bus.in_ready  = w_rdy[0];
    assign bus.out_valid = r_v[DEPTH-1];
    assign bus.out_data  = w_q[DEPTH-1];
    assign bus.count     = r_count;

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
// Directed, table-driven bench for dff_pipe. A DEPTH=2 instance runs the
// streaming / full-pipe / back-pressure vector table; a DEPTH=4 instance runs
// the bubble-collapse sequence. Reset (initial and mid-stream) and, when
// DFF_PIPE_FLUSH_EN is defined, flush are hand-written sequences.
// Inputs change #1 after the rising edge; outputs are checked on the falling
// edge, so each row's expectations describe the cycle before the next edge.
// -----------------------------------------------------------------------------
module tb_dff_pipe;
    import dff_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dff_pipe_if #(.WIDTH(W), .DEPTH(2)) if2 ();
    dff_pipe_if #(.WIDTH(W), .DEPTH(4)) if4 ();

    dff_pipe #(.WIDTH(W), .DEPTH(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2.slave)
    );

    dff_pipe #(.WIDTH(W), .DEPTH(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic          iv;
        logic [W-1:0]  id;
        logic          ordy;
        logic          ov;
        logic [W-1:0]  od;
        logic          ir;
        logic [31:0]   cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic iv, input logic [W-1:0] id, input logic ordy,
                                input logic ov, input logic [W-1:0] od, input logic ir,
                                input logic [31:0] cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.od = od; v.ir = ir; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic ov, input logic [W-1:0] od,
                        input logic ir, input logic [31:0] cnt);
        check({tag, "_ov"},  32'(if2.out_valid), 32'(ov));
        check({tag, "_od"},  if2.out_data, od);
        check({tag, "_ir"},  32'(if2.in_ready), 32'(ir));
        check({tag, "_cnt"}, 32'(if2.count), cnt);
    endtask

    task automatic chk4(input string tag, input logic ov, input logic [W-1:0] od,
                        input logic ir, input logic [31:0] cnt);
        check({tag, "_ov"},  32'(if4.out_valid), 32'(ov));
        check({tag, "_od"},  if4.out_data, od);
        check({tag, "_ir"},  32'(if4.in_ready), 32'(ir));
        check({tag, "_cnt"}, 32'(if4.count), cnt);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Streaming 0x1..0x8 with out_ready=1 (includes full-pipe pass-through).
        tbl[0]  = mk(1'b1, 32'h1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd0);
        tbl[1]  = mk(1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 1'b1, 32'd1);
        tbl[2]  = mk(1'b1, 32'h3, 1'b1, 1'b1, 32'h1, 1'b1, 32'd2);
        tbl[3]  = mk(1'b1, 32'h4, 1'b1, 1'b1, 32'h2, 1'b1, 32'd2);
        tbl[4]  = mk(1'b1, 32'h5, 1'b1, 1'b1, 32'h3, 1'b1, 32'd2);
        tbl[5]  = mk(1'b1, 32'h6, 1'b1, 1'b1, 32'h4, 1'b1, 32'd2);
        tbl[6]  = mk(1'b1, 32'h7, 1'b1, 1'b1, 32'h5, 1'b1, 32'd2);
        tbl[7]  = mk(1'b1, 32'h8, 1'b1, 1'b1, 32'h6, 1'b1, 32'd2);
        tbl[8]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h7, 1'b1, 32'd2);
        tbl[9]  = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'd1);
        tbl[10] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, 32'd0);
        // Back-pressure: 0xA, 0xB accepted, 0xC held until out_ready returns.
        tbl[11] = mk(1'b1, 32'hA, 1'b0, 1'b0, 32'h8, 1'b1, 32'd0);
        tbl[12] = mk(1'b1, 32'hB, 1'b0, 1'b0, 32'h8, 1'b1, 32'd1);
        tbl[13] = mk(1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 32'd2);
        tbl[14] = mk(1'b1, 32'hC, 1'b0, 1'b1, 32'hA, 1'b0, 32'd2);
        tbl[15] = mk(1'b1, 32'hC, 1'b1, 1'b1, 32'hA, 1'b1, 32'd2);
        tbl[16] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hB, 1'b1, 32'd2);
        tbl[17] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'd1);
        tbl[18] = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b1, 32'd0);

        // ---- Reset with a beat on the input ----
        reset         = 1'b0;
        if2.in_valid  = 1'b1;
        if2.in_data   = 32'hDEADBEEF;
        if2.out_ready = 1'b1;
        if4.in_valid  = 1'b1;
        if4.in_data   = 32'hDEADBEEF;
        if4.out_ready = 1'b1;
`ifdef DFF_PIPE_FLUSH_EN
        if2.flush     = 1'b0;
        if4.flush     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset        = 1'b1;
        if2.in_valid = 1'b0;
        if4.in_valid = 1'b0;
        @(negedge clk);
        chk2("rst2", 1'b0, 32'h0, 1'b1, 32'd0);
        chk4("rst4", 1'b0, 32'h0, 1'b1, 32'd0);
        next_cycle();

        // ---- Vector table on the DEPTH=2 instance ----
        for (int i = 0; i < 19; i++) begin
            if2.in_valid  = tbl[i].iv;
            if2.in_data   = tbl[i].id;
            if2.out_ready = tbl[i].ordy;
            @(negedge clk);
            chk2($sformatf("vec%0d", i), tbl[i].ov, tbl[i].od, tbl[i].ir, tbl[i].cnt);
            next_cycle();
        end

        // ---- Bubble collapse on the DEPTH=4 instance ----
        if4.out_ready = 1'b0;
        if4.in_valid  = 1'b1;
        if4.in_data   = 32'h55;
        @(negedge clk);
        chk4("bub_acc", 1'b0, 32'h0, 1'b1, 32'd0);
        next_cycle();
        if4.in_valid = 1'b0;
        if4.in_data  = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 4) begin
                chk4($sformatf("bub%0d", c), 1'b1, 32'h55, 1'b1, 32'd1);
            end else begin
                chk4($sformatf("bub%0d", c), 1'b0, 32'h0, 1'b1, 32'd1);
            end
            next_cycle();
        end
        if4.out_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        chk4("bub_drained", 1'b0, 32'h55, 1'b1, 32'd0);
        next_cycle();

`ifdef DFF_PIPE_FLUSH_EN
        // ---- Flush with a concurrent input beat ----
        if2.out_ready = 1'b0;
        if2.in_valid  = 1'b1;
        if2.in_data   = 32'h11;
        next_cycle();
        if2.in_data   = 32'h22;
        next_cycle();
        if2.in_data   = 32'h99;
        if2.flush     = 1'b1;
        @(negedge clk);
        chk2("fl_pre", 1'b1, 32'h11, 1'b0, 32'd2);
        next_cycle();
        if2.flush     = 1'b0;
        if2.in_valid  = 1'b0;
        if2.in_data   = 32'h0;
        if2.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk2($sformatf("fl_post%0d", c), 1'b0, 32'h11, 1'b1, 32'd0);
            next_cycle();
        end
`endif

        // ---- Reset in the middle of traffic ----
        if2.out_ready = 1'b0;
        if2.in_valid  = 1'b1;
        if2.in_data   = 32'h11;
        next_cycle();
        if2.in_data   = 32'h22;
        next_cycle();
        @(negedge clk);
        check("mid_full_cnt", 32'(if2.count), 32'd2);
        if2.in_data   = 32'h33;
        reset         = 1'b0;
        next_cycle();
        reset         = 1'b1;
        if2.in_valid  = 1'b0;
        @(negedge clk);
        chk2("mid_rst", 1'b0, 32'h0, 1'b1, 32'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dff_pipe
